// File: rtl/bit_packer.sv
// bit_packer: joins a payload channel and a destination-address channel into
// one flit ({data, address}) and queues assembled flits in a small FIFO ahead
// of the output port. The send-side counterpart of the bit slicer: flit bits
// [FLIT_W-1:ADDR_W] carry the payload, bits [ADDR_W-1:0] carry the address.
//
// Optional feature macro: BIT_PACKER_COUNT_EN adds the pkt_count output, a
// 16-bit wrapping count of flits assembled since reset.
//
// Ports:
//   clk            single clock, all state changes on its rising edge
//   reset          synchronous, active-high reset
//   in_data        payload word (DATA_W bits)
//   in_data_valid  payload offered
//   in_data_ready  payload accepted when valid & ready at a rising edge
//   in_addr        destination address (ADDR_W bits)
//   in_addr_valid  address offered
//   in_addr_ready  address accepted when valid & ready at a rising edge
//   out_flit       head-of-queue flit, 0 when the queue is empty
//   out_valid      flit available
//   out_ready      downstream accepts when out_valid & out_ready at an edge
//   pkt_count      flits assembled (only with BIT_PACKER_COUNT_EN)
module bit_packer #(
  parameter int DATA_W = 7,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_data_valid,
  output logic                     in_data_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic                     in_addr_valid,
  output logic                     in_addr_ready,
  output logic [DATA_W+ADDR_W-1:0] out_flit,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef BIT_PACKER_COUNT_EN
  ,
  output logic [15:0]              pkt_count
`endif
);

  localparam int FLIT_W = DATA_W + ADDR_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic              data_full;
  logic [DATA_W-1:0] data_reg;
  logic              addr_full;
  logic [ADDR_W-1:0] addr_reg;

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic join_now;
  logic pop;
  logic data_take;
  logic addr_take;

  // A join needs both halves present and a free FIFO slot. A pop in the same
  // cycle does not free a slot for a join, so a full queue always blocks.
  assign join_now  = data_full & addr_full & (count < DEPTH_C);
  assign pop       = out_valid & out_ready;

  // A holding register can reload in the same cycle its content joins.
  assign in_data_ready = ~reset & (~data_full | join_now);
  assign in_addr_ready = ~reset & (~addr_full | join_now);
  assign data_take     = in_data_valid & in_data_ready;
  assign addr_take     = in_addr_valid & in_addr_ready;

  assign out_valid = (count != '0);
  assign out_flit  = out_valid ? mem[rd_ptr] : '0;

  // Holding registers, FIFO pointers and occupancy. A reload takes priority
  // over the clear caused by a join so the next value is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_full <= 1'b0;
      data_reg  <= '0;
      addr_full <= 1'b0;
      addr_reg  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      if (data_take) begin
        data_full <= 1'b1;
        data_reg  <= in_data;
      end else if (join_now) begin
        data_full <= 1'b0;
      end

      if (addr_take) begin
        addr_full <= 1'b1;
        addr_reg  <= in_addr;
      end else if (join_now) begin
        addr_full <= 1'b0;
      end

      if (join_now) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end

      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end

      case ({join_now, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (!reset && join_now) begin
      mem[wr_ptr] <= {data_reg, addr_reg};
    end
  end

`ifdef BIT_PACKER_COUNT_EN
  logic [15:0] pkt_count_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count_r <= '0;
    end else if (join_now) begin
      pkt_count_r <= pkt_count_r + 16'd1;
    end
  end

  assign pkt_count = pkt_count_r;
`endif

endmodule

// File: tb/tb_bit_packer.sv
// Directed testbench for bit_packer with the default configuration
// (DATA_W = 7, ADDR_W = 4, DEPTH = 2). Inputs change 1 time unit after a rising
// edge and outputs are examined there too, away from the edge itself.
module tb_bit_packer;

  logic        clk;
  logic        reset;
  logic [6:0]  in_data;
  logic        in_data_valid;
  logic        in_data_ready;
  logic [3:0]  in_addr;
  logic        in_addr_valid;
  logic        in_addr_ready;
  logic [10:0] out_flit;
  logic        out_valid;
  logic        out_ready;
`ifdef BIT_PACKER_COUNT_EN
  logic [15:0] pkt_count;
`endif

  int checks;
  int errors;

  bit_packer #(.DATA_W(7), .ADDR_W(4), .DEPTH(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_data_valid (in_data_valid),
    .in_data_ready (in_data_ready),
    .in_addr       (in_addr),
    .in_addr_valid (in_addr_valid),
    .in_addr_ready (in_addr_ready),
    .out_flit      (out_flit),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
`ifdef BIT_PACKER_COUNT_EN
    ,
    .pkt_count     (pkt_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_data_valid = 1'b0;
    in_addr_valid = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    checks++;
    if (in_data_ready !== 1'b0 || in_addr_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_readies: got %b%b expected 00", in_data_ready, in_addr_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || out_flit !== 11'h000) begin
      errors++;
      $display("[TB] FAIL reset_out: got valid=%b flit=%h expected 0/000", out_valid, out_flit);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_data_ready !== 1'b1 || in_addr_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_readies: got %b%b expected 11", in_data_ready, in_addr_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || out_flit !== 11'h000) begin
      errors++;
      $display("[TB] FAIL post_reset_out: got valid=%b flit=%h expected 0/000", out_valid, out_flit);
    end
`ifdef BIT_PACKER_COUNT_EN
    checks++;
    if (pkt_count !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL post_reset_count: got %h expected 0000", pkt_count);
    end
`endif
    step();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    in_data = 7'h55;
    in_addr = 4'hA;
    in_data_valid = 1'b1;
    in_addr_valid = 1'b1;
    #1;
    checks++;
    if (in_data_ready !== 1'b1 || in_addr_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_ready: got %b%b expected 11", in_data_ready, in_addr_ready);
    end
    step();
    in_data_valid = 1'b0;
    in_addr_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_early: got valid=%b expected 0", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_flit !== 11'h55A) begin
      errors++;
      $display("[TB] FAIL basic_flit: got valid=%b flit=%h expected 1/55a", out_valid, out_flit);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_flit !== 11'h000) begin
      errors++;
      $display("[TB] FAIL basic_single: got valid=%b flit=%h expected 0/000", out_valid, out_flit);
    end
  endtask

  task automatic test_skew();
    out_ready = 1'b1;
    in_addr = 4'h3;
    in_addr_valid = 1'b1;
    step();
    in_addr_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (in_addr_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL skew_wait[%0d]: got addr_ready=%b valid=%b expected 0/0", i, in_addr_ready, out_valid);
      end
      step();
    end
    in_data = 7'h7F;
    in_data_valid = 1'b1;
    #1;
    checks++;
    if (in_data_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL skew_data_ready: got %b expected 1", in_data_ready);
    end
    step();
    in_data_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_flit !== 11'h7F3) begin
      errors++;
      $display("[TB] FAIL skew_flit: got valid=%b flit=%h expected 1/7f3", out_valid, out_flit);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL skew_drain: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [10:0] expect_q [4];
    int k;
    expect_q[0] = 11'h011;
    expect_q[1] = 11'h022;
    expect_q[2] = 11'h033;
    expect_q[3] = 11'h044;
    out_ready = 1'b0;
    in_data_valid = 1'b1;
    in_addr_valid = 1'b1;
    for (int p = 1; p <= 3; p++) begin
      in_data = 7'(p);
      in_addr = 4'(p);
      #1;
      checks++;
      if (in_data_ready !== 1'b1 || in_addr_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bp_accept[%0d]: got %b%b expected 11", p, in_data_ready, in_addr_ready);
      end
      step();
    end
    in_data = 7'h04;
    in_addr = 4'h4;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_data_ready !== 1'b0 || in_addr_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_stall[%0d]: got %b%b expected 00", i, in_data_ready, in_addr_ready);
      end
      checks++;
      if (out_valid !== 1'b1 || out_flit !== 11'h011) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: got valid=%b flit=%h expected 1/011", i, out_valid, out_flit);
      end
      step();
    end
    out_ready = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
      logic drop_data;
      logic drop_addr;
      #1;
      drop_data = in_data_valid & in_data_ready;
      drop_addr = in_addr_valid & in_addr_ready;
      if (out_valid) begin
        checks++;
        if (out_flit !== expect_q[k]) begin
          errors++;
          $display("[TB] FAIL bp_order[%0d]: got %h expected %h", k, out_flit, expect_q[k]);
        end
        k++;
      end
      step();
      if (drop_data) in_data_valid = 1'b0;
      if (drop_addr) in_addr_valid = 1'b0;
    end
    checks++;
    if (k != 4) begin
      errors++;
      $display("[TB] FAIL bp_timeout: got %0d flits expected 4", k);
    end
    in_data_valid = 1'b0;
    in_addr_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_drain: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] d;
    logic [10:0] exp_flit;
    out_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      if (c < 16) begin
        in_data = 7'(c * 5 + 3);
        in_addr = 4'(c);
        in_data_valid = 1'b1;
        in_addr_valid = 1'b1;
      end else begin
        in_data_valid = 1'b0;
        in_addr_valid = 1'b0;
      end
      #1;
      if (c < 16) begin
        checks++;
        if (in_data_ready !== 1'b1 || in_addr_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL b2b_ready[%0d]: got %b%b expected 11", c, in_data_ready, in_addr_ready);
        end
      end
      if (c >= 2) begin
        d = 7'((c - 2) * 5 + 3);
        exp_flit = {d, 4'(c - 2)};
        checks++;
        if (out_valid !== 1'b1 || out_flit !== exp_flit) begin
          errors++;
          $display("[TB] FAIL b2b_flit[%0d]: got valid=%b flit=%h expected 1/%h", c - 2, out_valid, out_flit, exp_flit);
        end
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_drain: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_data_valid = 1'b1;
    in_addr_valid = 1'b1;
    in_data = 7'h11;
    in_addr = 4'h1;
    step();
    in_data = 7'h12;
    in_addr = 4'h2;
    step();
    in_addr_valid = 1'b0;
    in_data = 7'h33;
    step();
    in_data_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_flit !== 11'h111) begin
      errors++;
      $display("[TB] FAIL rm_queued: got valid=%b flit=%h expected 1/111", out_valid, out_flit);
    end
    // A handshake offered during the reset cycle must be ignored.
    reset = 1'b1;
    in_data = 7'h44;
    in_data_valid = 1'b1;
    #1;
    checks++;
    if (in_data_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rm_reset_ready: got %b expected 0", in_data_ready);
    end
    step();
    reset = 1'b0;
    in_data_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_flit !== 11'h000) begin
      errors++;
      $display("[TB] FAIL rm_cleared: got valid=%b flit=%h expected 0/000", out_valid, out_flit);
    end
    checks++;
    if (in_data_ready !== 1'b1 || in_addr_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rm_readies: got %b%b expected 11", in_data_ready, in_addr_ready);
    end
    out_ready = 1'b1;
    in_data = 7'h21;
    in_addr = 4'h5;
    in_data_valid = 1'b1;
    in_addr_valid = 1'b1;
    step();
    in_data_valid = 1'b0;
    in_addr_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rm_stale: got valid=%b flit=%h expected 0", out_valid, out_flit);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_flit !== 11'h215) begin
      errors++;
      $display("[TB] FAIL rm_next: got valid=%b flit=%h expected 1/215", out_valid, out_flit);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rm_drain: got valid=%b flit=%h expected 0", out_valid, out_flit);
    end
  endtask

`ifdef BIT_PACKER_COUNT_EN
  task automatic test_counter();
    logic [15:0] exp_cnt [3];
    exp_cnt[0] = 16'hFFFF;
    exp_cnt[1] = 16'h0000;
    exp_cnt[2] = 16'h0001;
    force dut.pkt_count_r = 16'hFFFE;
    #1;
    release dut.pkt_count_r;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c < 3) begin
        in_data = 7'(c + 1);
        in_addr = 4'(c + 1);
        in_data_valid = 1'b1;
        in_addr_valid = 1'b1;
      end else begin
        in_data_valid = 1'b0;
        in_addr_valid = 1'b0;
      end
      step();
      if (c >= 1) begin
        checks++;
        if (pkt_count !== exp_cnt[c - 1]) begin
          errors++;
          $display("[TB] FAIL count_wrap[%0d]: got %h expected %h", c - 1, pkt_count, exp_cnt[c - 1]);
        end
      end
    end
    step();
    step();
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    in_data = '0;
    in_addr = '0;
    in_data_valid = 1'b0;
    in_addr_valid = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_skew();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef BIT_PACKER_COUNT_EN
    test_counter();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
